// File: rtl/mutex_lock_master_if.sv
// +--------------------------------------------------------------------------+
// | mutex_lock_master_if : Avalon-MM bus between mutex master and mutex slave |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mutex_lock_master_if;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  modport master (
    output m_address, m_read, m_write, m_writedata, m_byteenable,
    input  m_readdata, m_waitrequest
  );

  modport slave (
    input  m_address, m_read, m_write, m_writedata, m_byteenable,
    output m_readdata, m_waitrequest
  );
endinterface

`default_nettype wire

// File: rtl/mutex_lock_master.sv
// +--------------------------------------------------------------------------+
// | mutex_lock_master : acquires/releases a hardware mutex for a req/grant    |
// | client via write / read-back / backoff-retry on an Avalon-MM master. r1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module mutex_lock_master #(
  parameter logic [15:0] OWNER_ID       = 16'h0001,
  parameter logic [15:0] LOCK_VALUE     = 16'h0001,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          BACKOFF_CYCLES = 16,
  parameter logic [7:0]  MAX_RETRIES    = 8'd0
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  mutex_lock_master_if.master  bus,
  input  wire logic            lock_req,
  output logic                 lock_grant,
  output logic                 lock_fail,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACQ_WR  = 3'd1,
    S_ACQ_RD  = 3'd2,
    S_BACKOFF = 3'd3,
    S_HELD    = 3'd4,
    S_REL_WR  = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

  localparam logic [31:0] ACQ_WORD     = {OWNER_ID, LOCK_VALUE};
  localparam logic [31:0] REL_WORD     = {OWNER_ID, 16'h0000};
  localparam logic [15:0] BACKOFF_LOAD = 16'(BACKOFF_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  retry_cnt, retry_nxt;
  logic [15:0] backoff_cnt, backoff_nxt;
  logic        wr_nxt, rd_nxt;
  logic [31:0] wdata_nxt;
  logic        xfer_done;

  assign xfer_done        = (bus.m_read | bus.m_write) & ~bus.m_waitrequest;
  assign bus.m_address    = BASE_ADDR;
  assign bus.m_byteenable = 4'hF;

  always_comb begin
    state_nxt   = state;
    retry_nxt   = retry_cnt;
    backoff_nxt = backoff_cnt;
    case (state)
      S_IDLE: begin
        if (lock_req) begin
          retry_nxt = 8'd0;
          state_nxt = S_ACQ_WR;
        end
      end
      S_ACQ_WR: begin
        // A started Avalon write cannot be aborted; a dropped request turns into a release.
        if (xfer_done) state_nxt = lock_req ? S_ACQ_RD : S_REL_WR;
      end
      S_ACQ_RD: begin
        if (xfer_done) begin
          if (bus.m_readdata == ACQ_WORD) begin
            state_nxt = S_HELD;
          end else begin
            retry_nxt = (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;
            if ((MAX_RETRIES != 8'd0) && (retry_nxt == MAX_RETRIES)) begin
              state_nxt = S_FAIL;
            end else begin
              state_nxt   = S_BACKOFF;
              backoff_nxt = BACKOFF_LOAD;
            end
          end
        end
      end
      S_BACKOFF: begin
        if (!lock_req)                state_nxt   = S_IDLE;
        else if (backoff_cnt == 16'd0) state_nxt   = S_ACQ_WR;
        else                          backoff_nxt = backoff_cnt - 16'd1;
      end
      S_HELD:   if (!lock_req) state_nxt = S_REL_WR;
      S_REL_WR: if (xfer_done) state_nxt = S_IDLE;
      S_FAIL:   if (!lock_req) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they stay put across waitrequest stalls.
  always_comb begin
    wr_nxt    = (state_nxt == S_ACQ_WR) || (state_nxt == S_REL_WR);
    rd_nxt    = (state_nxt == S_ACQ_RD);
    wdata_nxt = bus.m_writedata;
    if (state_nxt == S_ACQ_WR)      wdata_nxt = ACQ_WORD;
    else if (state_nxt == S_REL_WR) wdata_nxt = REL_WORD;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      retry_cnt       <= 8'd0;
      backoff_cnt     <= 16'd0;
      bus.m_read      <= 1'b0;
      bus.m_write     <= 1'b0;
      bus.m_writedata <= 32'h0;
    end else begin
      state           <= state_nxt;
      retry_cnt       <= retry_nxt;
      backoff_cnt     <= backoff_nxt;
      bus.m_read      <= rd_nxt;
      bus.m_write     <= wr_nxt;
      bus.m_writedata <= wdata_nxt;
    end
  end

  assign lock_grant = (state == S_HELD);
  assign lock_fail  = (state == S_FAIL);
  assign busy       = (state == S_ACQ_WR) || (state == S_ACQ_RD) ||
                      (state == S_BACKOFF) || (state == S_REL_WR);

endmodule

`default_nettype wire

// File: tb/tb_mutex_lock_master.sv
// +--------------------------------------------------------------------------+
// | tb_mutex_lock_master : directed + randomized bench with mutex slave model |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mutex_lock_master;

  localparam logic [31:0] ACQ     = 32'h0001_0001;
  localparam logic [31:0] REL     = 32'h0001_0000;
  localparam int          BACKOFF = 16;
  localparam int          MAXR    = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic lock_req;
  logic lock_grant, lock_fail, busy;
  logic force_wait = 1'b0;
  logic rnd_wait   = 1'b0;
  int   wprob      = 0;
  int   cpu_cmd    = 3;
  logic [15:0] mtx_owner = 16'h0, mtx_value = 16'h0;
  logic [15:0] nx_owner, nx_value;

  int total, bad;
  int n_acq = 0, n_rel = 0, n_rd = 0, n_rdfail = 0, ep_base = 0;
  logic [31:0] last_rd = 32'h0;

  mutex_lock_master_if bus();

  mutex_lock_master #(
    .OWNER_ID(16'h0001), .LOCK_VALUE(16'h0001), .BASE_ADDR(32'h0),
    .BACKOFF_CYCLES(BACKOFF), .MAX_RETRIES(8'(MAXR))
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master),
    .lock_req(lock_req), .lock_grant(lock_grant), .lock_fail(lock_fail), .busy(busy)
  );

  always #5 clk = ~clk;

  // Mutex slave: a write lands only if the mutex is free or the owner matches.
  // cpu_cmd: 1 = other owner (2) grabs if free, 2 = owner 2 releases, 3 = slave reset.
  assign bus.m_readdata    = {mtx_owner, mtx_value};
  assign bus.m_waitrequest = force_wait | rnd_wait;

  always_comb begin
    nx_owner = mtx_owner;
    nx_value = mtx_value;
    if (bus.m_write && !bus.m_waitrequest &&
        (mtx_value == 16'h0 || bus.m_writedata[31:16] == mtx_owner)) begin
      nx_owner = bus.m_writedata[31:16];
      nx_value = bus.m_writedata[15:0];
    end
    case (cpu_cmd)
      1: if (nx_value == 16'h0) begin nx_owner = 16'h2; nx_value = 16'h1; end
      2: if (nx_owner == 16'h2) nx_value = 16'h0;
      3: begin nx_owner = 16'h0; nx_value = 16'h0; end
      default: ;
    endcase
  end

  always @(posedge clk) begin
    mtx_owner <= nx_owner;
    mtx_value <= nx_value;
    rnd_wait  <= (wprob > 0) && ($urandom_range(0, 99) < wprob);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu(input int cmd);
    cpu_cmd = cmd;
    tick(1);
    cpu_cmd = 0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick(1);
      ok = !busy && !lock_grant && !lock_fail && !bus.m_read && !bus.m_write;
    end
    check({tag, "_idle"}, 32'(ok), 1);
  endtask

  task automatic wait_grant(input string tag, input int limit, output int lat);
    lat = 0;
    while (!lock_grant && lat < limit) begin
      tick(1);
      lat++;
    end
    check({tag, "_grant"}, 32'(lock_grant), 1);
  endtask

  task automatic wait_fails(input string tag, input int n);
    int i = 0;
    while ((n_rdfail - ep_base) < n && i < 200) begin
      tick(1);
      i++;
    end
    check({tag, "_fails"}, n_rdfail - ep_base, n);
  endtask

  // Bus observer: protocol rules plus the expected reaction to each read-back.
  task automatic monitor();
    logic        hold, h_rd, h_wr, prev_fail, gap_req, gap_chk, exp_grant, exp_fail_chk, exp_fail, rd_ok;
    logic [31:0] h_data;
    int          gap;
    hold = 0; h_rd = 0; h_wr = 0; h_data = 0; prev_fail = 0; gap = 0; gap_req = 0;
    gap_chk = 0; exp_grant = 0; exp_fail_chk = 0; exp_fail = 0; rd_ok = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold = 0; gap = 0; gap_chk = 0; exp_grant = 0; exp_fail_chk = 0; rd_ok = 0; prev_fail = 0;
        continue;
      end
      check("rd_and_wr", 32'(bus.m_read & bus.m_write), 0);
      if (hold) begin
        check("hold_rd", 32'(bus.m_read), 32'(h_rd));
        check("hold_wr", 32'(bus.m_write), 32'(h_wr));
        check("hold_data", bus.m_writedata, h_data);
      end
      if (bus.m_read || bus.m_write) begin
        check("busy_on_strobe", 32'(busy), 1);
        check("address", bus.m_address, 32'h0);
        check("byteenable", 32'(bus.m_byteenable), 32'hF);
      end
      if (lock_grant) check("grant_owned", {mtx_owner, mtx_value}, ACQ);
      if (lock_grant || lock_fail) check("quiet_when_settled", 32'(bus.m_read | bus.m_write | busy), 0);
      if (exp_grant) check("grant_after_rd", 32'(lock_grant), 1);
      if (exp_fail_chk) check("fail_after_rd", 32'(lock_fail), 32'(exp_fail));
      if (lock_fail && !prev_fail) check("fail_count", n_rdfail - ep_base, MAXR);
      prev_fail = lock_fail;
      if (gap_chk) begin
        gap_chk = 0;
        if (gap_req && !lock_fail) check("backoff_retry_wr", {31'b0, bus.m_write}, 1);
      end
      if (gap > 0) begin
        check("backoff_quiet", 32'(bus.m_read | bus.m_write), 0);
        if (!lock_req) gap_req = 0;
        gap--;
        if (gap == 0) gap_chk = 1;
      end
      exp_grant = 0;
      exp_fail_chk = 0;
      if (bus.m_write && !bus.m_waitrequest) begin
        if (bus.m_writedata == ACQ) begin
          n_acq++;
          rd_ok = 1;
        end else begin
          check("wdata_rel", bus.m_writedata, REL);
          n_rel++;
          rd_ok = 0;
        end
      end
      if (bus.m_read && !bus.m_waitrequest) begin
        check("rd_after_acq_wr", 32'(rd_ok), 1);
        rd_ok = 0;
        n_rd++;
        last_rd = bus.m_readdata;
        if (bus.m_readdata == ACQ) begin
          exp_grant = 1;
        end else begin
          n_rdfail++;
          check("retry_bound", 32'((n_rdfail - ep_base) <= MAXR), 1);
          exp_fail_chk = 1;
          exp_fail = ((n_rdfail - ep_base) == MAXR);
          gap = BACKOFF;
          gap_req = 1;
        end
      end
      hold   = (bus.m_read || bus.m_write) && bus.m_waitrequest;
      h_rd   = bus.m_read;
      h_wr   = bus.m_write;
      h_data = bus.m_writedata;
    end
  endtask

  initial begin
    int lat, s_acq, s_rd, s_rel, s_all, hold_len, r;
    total = 0; bad = 0;
    reset_n = 1'b0; lock_req = 1'b0;
    fork monitor(); join_none

    // Reset state
    tick(2);
    check("rst_read", 32'(bus.m_read), 0);
    check("rst_write", 32'(bus.m_write), 0);
    check("rst_wdata", bus.m_writedata, 0);
    check("rst_grant", 32'(lock_grant), 0);
    check("rst_fail", 32'(lock_fail), 0);
    check("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    cpu_cmd = 0;
    tick(2);

    // Uncontended acquire and release
    s_acq = n_acq; s_rd = n_rd; ep_base = n_rdfail;
    lock_req = 1'b1;
    wait_grant("unc", 20, lat);
    check("unc_latency", lat, 3);
    check("unc_acq_wr", n_acq - s_acq, 1);
    check("unc_rd", n_rd - s_rd, 1);
    check("unc_rd_data", last_rd, ACQ);
    tick(3);
    lock_req = 1'b0;
    tick(1);
    check("rel_issue_wr", 32'(bus.m_write), 1);
    check("rel_issue_data", bus.m_writedata, REL);
    wait_idle("unc");
    check("unc_slave_free", 32'(mtx_value), 0);

    // Contention: owner 2 holds, released during the second backoff
    cpu(1);
    s_rd = n_rd; ep_base = n_rdfail;
    lock_req = 1'b1;
    wait_fails("cont", 2);
    check("cont_no_grant", 32'(lock_grant), 0);
    cpu(2);
    wait_grant("cont", 60, lat);
    check("cont_reads", n_rd - s_rd, 3);
    check("cont_fail_reads", n_rdfail - ep_base, 2);
    lock_req = 1'b0;
    wait_idle("cont");
    check("cont_slave_free", 32'(mtx_value), 0);
    tick(20);

    // Retry limit
    cpu(1);
    s_acq = n_acq; s_rd = n_rd; ep_base = n_rdfail;
    lock_req = 1'b1;
    lat = 0;
    while (!lock_fail && lat < 200) begin tick(1); lat++; end
    check("lim_fail", 32'(lock_fail), 1);
    check("lim_wr_pairs", n_acq - s_acq, 3);
    check("lim_rd_pairs", n_rd - s_rd, 3);
    s_all = n_acq + n_rd + n_rel;
    tick(40);
    check("lim_no_traffic", n_acq + n_rd + n_rel, s_all);
    check("lim_fail_held", 32'(lock_fail), 1);
    lock_req = 1'b0;
    tick(1);
    check("lim_fail_clear", 32'(lock_fail), 0);
    check("lim_idle_busy", 32'(busy), 0);
    cpu(2);
    tick(20);

    // Waitrequest stall: 5 stalled edges on both the write and the read
    s_acq = n_acq; s_rd = n_rd; ep_base = n_rdfail;
    force_wait = 1'b1;
    lock_req = 1'b1;
    tick(6);
    check("stall_wr_held", 32'(bus.m_write), 1);
    force_wait = 1'b0;
    tick(1);
    force_wait = 1'b1;
    tick(5);
    check("stall_rd_held", 32'(bus.m_read), 1);
    force_wait = 1'b0;
    wait_grant("stall", 20, lat);
    check("stall_latency", 12 + lat, 13);
    check("stall_one_wr", n_acq - s_acq, 1);
    check("stall_one_rd", n_rd - s_rd, 1);
    lock_req = 1'b0;
    wait_idle("stall");

    // Abort during backoff: no release write
    cpu(1);
    ep_base = n_rdfail;
    lock_req = 1'b1;
    wait_fails("abo", 1);
    tick(5);
    lock_req = 1'b0;
    s_all = n_acq + n_rd + n_rel;
    tick(30);
    check("abo_no_traffic", n_acq + n_rd + n_rel, s_all);
    check("abo_busy", 32'(busy), 0);
    check("abo_slave_owner2", {mtx_owner, mtx_value}, 32'h0002_0001);
    cpu(2);
    tick(2);

    // Abort during a stalled acquire write
    cpu(3);
    s_acq = n_acq; s_rd = n_rd; s_rel = n_rel; ep_base = n_rdfail;
    force_wait = 1'b1;
    lock_req = 1'b1;
    tick(2);
    lock_req = 1'b0;
    tick(2);
    force_wait = 1'b0;
    wait_idle("abw");
    check("abw_acq_wr", n_acq - s_acq, 1);
    check("abw_rel_wr", n_rel - s_rel, 1);
    check("abw_no_rd", n_rd - s_rd, 0);
    check("abw_slave_free", 32'(mtx_value), 0);
    tick(5);

    // Async reset while held, then while a write is stalled
    ep_base = n_rdfail;
    lock_req = 1'b1;
    wait_grant("rsth", 20, lat);
    #2 reset_n = 1'b0;
    #1;
    check("rsth_grant", 32'(lock_grant), 0);
    check("rsth_write", 32'(bus.m_write), 0);
    lock_req = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check("rsth_idle_busy", 32'(busy), 0);
    check("rsth_idle_grant", 32'(lock_grant), 0);
    check("rsth_slave_held", {mtx_owner, mtx_value}, ACQ);
    ep_base = n_rdfail;
    force_wait = 1'b1;
    lock_req = 1'b1;
    tick(1);
    check("rstw_wr_start", 32'(bus.m_write), 1);
    check("rstw_wr_data", bus.m_writedata, ACQ);
    tick(1);
    #2 reset_n = 1'b0;
    #1;
    check("rstw_write", 32'(bus.m_write), 0);
    check("rstw_busy", 32'(busy), 0);
    lock_req = 1'b0;
    force_wait = 1'b0;
    tick(1);
    reset_n = 1'b1;
    cpu(3);
    tick(2);

    // Randomized episodes with contention and random waitrequest
    for (int e = 0; e < 25; e++) begin
      wprob = $urandom_range(0, 60);
      ep_base = n_rdfail;
      lock_req = 1'b1;
      hold_len = $urandom_range(5, 120);
      for (int k = 0; k < hold_len; k++) begin
        r = $urandom_range(0, 99);
        cpu_cmd = (r < 5) ? 1 : (r < 10) ? 2 : 0;
        tick(1);
      end
      cpu_cmd = 0;
      lock_req = 1'b0;
      wait_idle("rnd");
      check("rnd_not_owned", 32'(mtx_owner == 16'h1 && mtx_value != 16'h0), 0);
      tick(20);
    end
    wprob = 0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
